// File: rtl/rv_inst_encoder_if.sv
// ---------------------------------------------------------------------------
// rv_inst_encoder_if
//   Field-bundle input stream and encoded-word output stream of
//   rv_inst_encoder, bundled as one interface.
//
//   master : the harness/driver side. It drives the field bundle and
//            out_ready, and it receives in_ready and the encoded word.
//   slave  : the encoder side.
//
//   in_valid/in_ready   field bundle handshake
//   in_fmt              0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//   in_opcode/funct3/funct7/rd/rs1/rs2/imm   decoded instruction fields
//   out_valid/out_ready encoded word handshake
//   out_inst            32-bit instruction word
//   out_err             the word came from a bundle that cannot be encoded
// ---------------------------------------------------------------------------
interface rv_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/rv_inst_encoder.sv
// ---------------------------------------------------------------------------
// rv_inst_encoder
//   Streaming RV32/RV64 base-ISA instruction encoder. It assembles a 32-bit
//   instruction word from the decoded fields. The word passes through a
//   2-entry elastic buffer: an output register plus a skid register.
//   A bundle that cannot be encoded still produces a word, and that word
//   carries out_err=1.
//
//   clk        clock; all state updates on posedge
//   rst        synchronous, active-high reset
//   bus        rv_inst_encoder_if.slave (field input + word output streams)
//   inst_count output handshakes since reset (wraps)
//   err_count  output handshakes with out_err=1 (wraps)
// ---------------------------------------------------------------------------
module rv_inst_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  rv_inst_encoder_if.slave   bus,
  output logic [COUNT_W-1:0] inst_count,
  output logic [COUNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } word_t;

  // ---------------------------------------------------------------------
  // Combinational encoding of the bundle currently on the input.
  // ---------------------------------------------------------------------
  word_t       enc;
  logic [31:0] imm;

  assign imm = bus.in_imm;

  always_comb begin
    // NOTE: every output of this block gets a default before the case.
    // A path that does not assign a value would otherwise infer a latch.
    enc.inst = '0;
    enc.err  = 1'b0;
    case (bus.in_fmt)
      FMT_R: enc.inst = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                         bus.in_funct3, bus.in_rd, bus.in_opcode};
      FMT_I: begin
        enc.inst = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                    bus.in_opcode};
        enc.err  = (imm[31:11] != {21{imm[11]}});
      end
      FMT_S: begin
        enc.inst = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                    imm[4:0], bus.in_opcode};
        enc.err  = (imm[31:11] != {21{imm[11]}});
      end
      FMT_B: begin
        enc.inst = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                    bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
        // Branch offsets are even and must fit 13 signed bits.
        enc.err  = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      FMT_U: begin
        enc.inst = {imm[31:12], bus.in_rd, bus.in_opcode};
        // Bits [11:0] of the value are not representable in a U word.
        enc.err  = |imm[11:0];
      end
      FMT_J: begin
        enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd,
                    bus.in_opcode};
        enc.err  = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      default: begin
        enc.inst = '0;
        enc.err  = 1'b1;
      end
    endcase
    // All 32-bit base-ISA opcodes end in 2'b11.
    if (bus.in_opcode[1:0] != 2'b11) enc.err = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Two-entry elastic buffer: out_q feeds the output, skid_q absorbs one
  // word accepted while the output is stalled.
  // ---------------------------------------------------------------------
  word_t out_q;
  word_t skid_q;
  logic  out_valid_q;
  logic  skid_valid_q;
  logic  in_hs;
  logic  out_hs;

  // in_ready comes straight from a register, so there is no combinational
  // path from out_ready to in_ready.
  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_q.inst;
  assign bus.out_err   = out_q.err;

  assign in_hs  = bus.in_valid && !skid_valid_q;
  assign out_hs = out_valid_q && bus.out_ready;

  // NOTE: state is updated with non-blocking assignments only. Every
  // right-hand side then sees the pre-edge value, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset along with the valid bits,
      // because out_inst/out_err must read 0 after reset.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
      inst_count   <= '0;
      err_count    <= '0;
    end else begin
      if (out_hs) begin
        inst_count <= inst_count + COUNT_W'(1);
        if (out_q.err) err_count <= err_count + COUNT_W'(1);
      end

      if (!out_valid_q || bus.out_ready) begin
        // The output register is free or draining this cycle.
        if (skid_valid_q) begin
          // Oldest word first: the skid moves to the output, and any new
          // word takes its place.
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= in_hs;
          if (in_hs) skid_q <= enc;
        end else begin
          out_valid_q <= in_hs;
          if (in_hs) out_q <= enc;
        end
      end else if (in_hs) begin
        // The output is stalled: park the new word in the skid register.
        skid_q       <= enc;
        skid_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv_inst_encoder
//   Self-checking bench for rv_inst_encoder. The reference model is a
//   2-deep FIFO (a queue) of words, each encoded from the instruction-format
//   rules with integer arithmetic. Every cycle the bench compares the DUT
//   against this model. Directed steps follow the test plan. A randomized
//   phase and a counter wrap run follow them.
// ---------------------------------------------------------------------------
module tb_rv_inst_encoder;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] inst_count;
  logic [CW-1:0] err_count;

  always #5 clk = ~clk;

  rv_inst_encoder_if bus ();

  rv_inst_encoder #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .inst_count (inst_count),
    .err_count  (err_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } word_t;

  word_t         q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] m_inst_cnt = '0;
  logic [CW-1:0] m_err_cnt  = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder, built from the format rules with integer arithmetic.
  function automatic word_t ref_encode();
    word_t       w;
    int unsigned op  = 32'(bus.in_opcode);
    int unsigned f3  = 32'(bus.in_funct3);
    int unsigned f7  = 32'(bus.in_funct7);
    int unsigned rd  = 32'(bus.in_rd);
    int unsigned rs1 = 32'(bus.in_rs1);
    int unsigned rs2 = 32'(bus.in_rs2);
    int unsigned u   = bus.in_imm;
    int          s   = int'(bus.in_imm);
    int unsigned base_rs = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | op;
    w.inst = 32'h0;
    w.err  = 1'b0;
    case (bus.in_fmt)
      3'd0: w.inst = (f7 << 25) | base_rs | (rd << 7);
      3'd1: begin
        w.inst = ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        w.err  = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w.inst = (((u >> 5) & 32'h7f) << 25) | base_rs | ((u & 32'h1f) << 7);
        w.err  = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w.inst = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | base_rs
               | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7);
        w.err  = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      3'd4: begin
        w.inst = (u & 32'hfffff000) | (rd << 7) | op;
        w.err  = (u % 4096) != 0;
      end
      3'd5: begin
        w.inst = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
               | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12)
               | (rd << 7) | op;
        w.err  = (s < -(1 << 20)) || (s >= (1 << 20)) || (s % 2 != 0);
      end
      default: begin
        w.inst = 32'h0;
        w.err  = 1'b1;
      end
    endcase
    if (op % 4 != 3) w.err = 1'b1;
    return w;
  endfunction

  // One clock cycle: compare the DUT with the model, predict this edge's
  // handshakes from the model's occupancy, then advance to the next negedge.
  task automatic cycle();
    bit ih;
    bit oh;
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      check("out_inst", bus.out_inst, q[0].inst);
      check("out_err", 32'(bus.out_err), 32'(q[0].err));
    end
    check("inst_count", 32'(inst_count), 32'(m_inst_cnt));
    check("err_count", 32'(err_count), 32'(m_err_cnt));
    oh = (q.size() != 0) && bus.out_ready;
    ih = bus.in_valid && (q.size() < 2);
    if (oh) begin
      m_inst_cnt++;
      if (q[0].err) m_err_cnt++;
      void'(q.pop_front());
    end
    if (ih) q.push_back(ref_encode());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  // Hold the current bundle valid until it is accepted (bounded).
  task automatic offer(input string tag);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (q.size() < 2);
      cycle();
    end
    bus.in_valid = 1'b0;
    check({"accept_", tag}, 32'(acc), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_inst_cnt = '0;
    m_err_cnt  = '0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields(3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    do_reset();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // addiw x8, x0, 1
    bus.out_ready = 1'b1;
    set_fields(3'd1, 7'h1b, 3'd0, 7'h0, 5'd8, 5'd0, 5'd0, 32'd1);
    offer("addiw");
    check("addiw_inst", bus.out_inst, 32'h0010041b);
    check("addiw_err", 32'(bus.out_err), 32'd0);
    cycle();
    check("addiw_count", 32'(inst_count), 32'd1);

    // auipc then addi back to back, no bubble
    set_fields(3'd4, 7'h17, 3'd0, 7'h0, 5'd11, 5'd0, 5'd0, 32'h0);
    bus.in_valid = 1'b1;
    cycle();
    check("auipc_inst", bus.out_inst, 32'h00000597);
    set_fields(3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'h0);
    cycle();
    bus.in_valid = 1'b0;
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_inst", bus.out_inst, 32'h00000093);
    cycle();

    // branches: a legal even offset, then an odd offset
    set_fields(3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, -32'sd4);
    offer("beq_m4");
    check("beq_m4_inst", bus.out_inst, 32'hfe208ee3);
    check("beq_m4_err", 32'(bus.out_err), 32'd0);
    set_fields(3'd3, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, -32'sd3);
    offer("beq_m3");
    check("beq_m3_err", 32'(bus.out_err), 32'd1);
    cycle();
    check("beq_m3_errcnt", 32'(err_count), 32'd1);

    // backpressure: two words buffered, the third held upstream
    bus.out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'h0);
    offer("bp_a");
    set_fields(3'd2, 7'h23, 3'd2, 7'h0, 5'd0, 5'd6, 5'd7, 32'd100);
    offer("bp_b");
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    set_fields(3'd5, 7'h6f, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
    bus.in_valid = 1'b1;
    repeat (3) cycle();
    check("bp_held_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    offer("bp_c");
    repeat (3) cycle();
    check("bp_drained", 32'(q.size()), 32'd0);

    // immediate range edges and an illegal format
    set_fields(3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd2048);
    offer("imm_2048");
    check("imm_2048_err", 32'(bus.out_err), 32'd1);
    set_fields(3'd1, 7'h13, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, -32'sd2048);
    offer("imm_m2048");
    check("imm_m2048_inst", bus.out_inst, 32'h80000013);
    check("imm_m2048_err", 32'(bus.out_err), 32'd0);
    set_fields(3'd7, 7'h13, 3'd1, 7'h1, 5'd1, 5'd1, 5'd1, 32'h1);
    offer("fmt7");
    check("fmt7_inst", bus.out_inst, 32'h0);
    check("fmt7_err", 32'(bus.out_err), 32'd1);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned kind = $urandom_range(0, 3);
      logic [31:0] imm;
      case (kind)
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        2: imm = $urandom() & 32'hfffff000;
        default: imm = $urandom();
      endcase
      set_fields(3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 7'($urandom()) : {5'($urandom()), 2'b11},
                 3'($urandom()), 7'($urandom()), 5'($urandom()),
                 5'($urandom()), 5'($urandom()), imm);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();

    // reset with two words buffered and handshakes requested in the same cycle
    bus.out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 3'd0, 7'h0, 5'd2, 5'd3, 5'd0, 32'd7);
    offer("rst_a");
    offer("rst_b");
    check("rst_pre_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    bus.in_valid = 1'b0;
    check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst2_inst_count", 32'(inst_count), 32'd0);
    check("rst2_err_count", 32'(err_count), 32'd0);
    check("rst2_out_inst", bus.out_inst, 32'h0);

    // counter wrap: stream legal words until inst_count reaches all-ones
    set_fields(3'd1, 7'h13, 3'd0, 7'h0, 5'd5, 5'd5, 5'd0, 32'd1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 70000 && m_inst_cnt != {CW{1'b1}}; i++) cycle();
    check("wrap_max", 32'(inst_count), 32'h0000ffff);
    cycle();
    check("wrap_zero", 32'(inst_count), 32'h0);
    bus.in_valid = 1'b0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Streaming RV32/RV64 base-ISA instruction encoder, the inverse of the controller decoders.
- Accepts decoded fields (format, opcode, funct, registers, immediate) and assembles the 32-bit instruction word.
- Sits in the decoder test harness as the stimulus source for controller_full/controller_star, and is reusable by any block that emits instructions.
- Elastic 2-entry buffer with valid/ready on both sides; flags field values that cannot be encoded.

Parameters:
COUNT_W, 16, width of the emitted-instruction and error counters (wrap-around).

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_opcode  input  7  major opcode
in_funct3  input  3  funct3 (R/I/S/B only)
in_funct7  input  7  funct7 (R only)
in_rd  input  5  destination register
in_rs1  input  5  source 1
in_rs2  input  5  source 2
in_imm  input  32  signed immediate, byte offset for B/J, full value for U
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts
out_inst  output  32  encoded instruction
out_err  output  1  word came from a non-encodable bundle
inst_count  output  COUNT_W  output handshakes since reset
err_count  output  COUNT_W  output handshakes with out_err=1

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, out_inst=0, out_err=0, inst_count=0, err_count=0.
  - Both buffer entries are emptied, discarding data mid-stream.
  - in_ready=1 from the first cycle after reset.
- Encoding (combinational on input, registered into the buffer), concatenated MSB→LSB:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Fields a format does not use are ignored.
- Error conditions (word still emitted, out_err=1):
  - opcode[1:0]!=2'b11
  - I/S: imm not a sign-extension of imm[11:0]
  - B: imm not a sign-extension of imm[12:0], or imm[0]=1
  - J: imm not a sign-extension of imm[20:0], or imm[0]=1
  - U: imm[11:0]!=0
  - fmt 6/7: out_inst=32'h00000000
- Buffer: 2 entries (output register + skid register); FIFO order preserved.
  - Input handshake = in_valid&in_ready.
  - Output handshake = out_valid&out_ready.
  - in_ready = !(skid entry occupied); registered, with no combinational path from out_ready.
  - Latency: a bundle accepted at edge N with an empty buffer shows out_valid=1 with its word after edge N.
  - Throughput: 1 word/cycle while out_ready=1.
  - Output empty or draining: an accept loads the output register directly.
  - Output held (out_valid&!out_ready): an accept fills the skid entry; in_ready drops the next cycle.
  - Simultaneous input and output handshake with skid occupied: skid moves to output, the new word goes to skid, occupancy stays 2.
  - Simultaneous handshakes with skid empty: the new word replaces output.
- Output stability: while out_valid&!out_ready, out_inst/out_err stay constant.
- Counters:
  - inst_count += 1 on each output handshake.
  - err_count += 1 on each output handshake with out_err=1.
  - Both wrap from 2^COUNT_W-1 to 0.
- rst has priority over all handshakes in the same cycle.

Test Plan:
- I fmt, opcode=0x1b, rd=8, rs1=0, f3=0, imm=1, out_ready=1 -> out_inst=0x0010041b one cycle later, out_err=0, inst_count=1.
- U fmt, opcode=0x17, rd=11, imm=0 -> 0x00000597; then I fmt, opcode=0x13, rd=1, imm=0 on back-to-back cycles -> 0x00000093 the next cycle, no bubble.
- B fmt, opcode=0x63, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3. Same with imm=-3 -> out_err=1, err_count=1.
- out_ready=0 with 3 consecutive valid bundles:
  - 2 accepted, then in_ready=0 and the third is held upstream.
  - out_inst stays stable.
  - Releasing out_ready drains all three in order.
- Edge cases:
  - I imm=2048 -> out_err=1.
  - I imm=-2048 -> ok, 0x80000013 for addi x0,x0.
  - fmt=7 -> out_inst=0, out_err=1.
- rst asserted with 2 words buffered -> out_valid=0, counters 0, in_ready=1 the next cycle. Preload inst_count to 0xFFFF by streaming words -> wraps to 0.
